// File: rtl/pwm_ramp_controller.sv
// Soft-start sequencer for the PWM duty reference: accepts a target via valid/ready
// and walks the reference toward it by a fixed step on selected PWM period boundaries.
module pwm_ramp_controller #(
  parameter int RESOLUTION_BITS = 8,
  parameter int PERIOD_CNT_BITS = 4
) (
  input  logic                       clk_ctrl,
  input  logic                       rst_ctrl,
  input  logic [RESOLUTION_BITS-1:0] target_in,
  input  logic [RESOLUTION_BITS-1:0] step_in,
  input  logic [PERIOD_CNT_BITS-1:0] periods_in,
  input  logic                       target_valid,
  output logic                       target_ready,
  input  logic                       period_tick,
  input  logic                       abort,
  output logic [RESOLUTION_BITS-1:0] referencia_out,
  output logic                       busy,
  output logic                       done
);

  localparam int EXT_BITS = RESOLUTION_BITS + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t                     state_reg, state_next;
  logic [RESOLUTION_BITS-1:0] ref_reg, ref_next;
  logic [RESOLUTION_BITS-1:0] target_reg, target_next;
  logic [RESOLUTION_BITS-1:0] step_reg, step_next;
  logic [PERIOD_CNT_BITS-1:0] periods_reg, periods_next;
  logic [PERIOD_CNT_BITS-1:0] cnt_reg, cnt_next;
  logic                       ready_reg, ready_next;
  logic                       busy_reg, busy_next;
  logic                       done_reg, done_next;

  logic                       transfer;
  logic                       update_due;
  logic [EXT_BITS-1:0]        ref_ext, target_ext, step_ext;
  logic [EXT_BITS-1:0]        distance, stepped_ext;
  logic                       going_up;
  logic [RESOLUTION_BITS-1:0] stepped_ref;

  assign transfer   = target_valid && ready_reg;
  assign update_due = (cnt_reg == (periods_reg - PERIOD_CNT_BITS'(1)));

  // One extra bit keeps ref +/- step from wrapping; the clamp to target
  // guarantees the truncated result is always in range.
  always_comb begin
    ref_ext    = {1'b0, ref_reg};
    target_ext = {1'b0, target_reg};
    step_ext   = {1'b0, step_reg};
    going_up   = (target_ext > ref_ext);
    distance   = going_up ? (target_ext - ref_ext) : (ref_ext - target_ext);
    if (distance <= step_ext) begin
      stepped_ext = target_ext;
    end else if (going_up) begin
      stepped_ext = ref_ext + step_ext;
    end else begin
      stepped_ext = ref_ext - step_ext;
    end
    stepped_ref = stepped_ext[RESOLUTION_BITS-1:0];
  end

  always_comb begin
    state_next   = state_reg;
    ref_next     = ref_reg;
    target_next  = target_reg;
    step_next    = step_reg;
    periods_next = periods_reg;
    cnt_next     = cnt_reg;
    ready_next   = ready_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        busy_next  = 1'b0;
        if (transfer) begin
          if (target_in == ref_reg) begin
            done_next = 1'b1;
          end else begin
            state_next   = RAMP;
            busy_next    = 1'b1;
            ready_next   = 1'b0;
            cnt_next     = '0;
            target_next  = target_in;
            // Zero step or zero period would stall the ramp forever.
            step_next    = (step_in == '0) ? RESOLUTION_BITS'(1) : step_in;
            periods_next = (periods_in == '0) ? PERIOD_CNT_BITS'(1) : periods_in;
          end
        end
      end

      RAMP: begin
        if (abort) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          ready_next = 1'b1;
          cnt_next   = '0;
        end else if (period_tick) begin
          if (update_due) begin
            cnt_next = '0;
            ref_next = stepped_ref;
            if (stepped_ref == target_reg) begin
              done_next  = 1'b1;
              state_next = IDLE;
              busy_next  = 1'b0;
              ready_next = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + PERIOD_CNT_BITS'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        ready_next = 1'b1;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_ctrl) begin
    if (rst_ctrl) begin
      state_reg   <= IDLE;
      ref_reg     <= '0;
      target_reg  <= '0;
      step_reg    <= RESOLUTION_BITS'(1);
      periods_reg <= PERIOD_CNT_BITS'(1);
      cnt_reg     <= '0;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ref_reg     <= ref_next;
      target_reg  <= target_next;
      step_reg    <= step_next;
      periods_reg <= periods_next;
      cnt_reg     <= cnt_next;
      ready_reg   <= ready_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign referencia_out = ref_reg;
  assign target_ready   = ready_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;

endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Soft-start / soft-change sequencer for the PWM generator's duty reference. It accepts a new target duty through a valid/ready handshake and steps its `referencia_out` toward that target by a programmable increment. Updates happen only on PWM period boundaries, spaced a programmable number of periods apart. `referencia_out` drives the generator's duty reference input. `period_tick` comes from the generator's period-boundary pulse.

## Interface

Parameters:
- `RESOLUTION_BITS`, 8: width of duty reference, target and step.
- `PERIOD_CNT_BITS`, 4: width of the periods-per-step field.

Ports:
- `clk_ctrl`, input, 1: system clock. Single clock domain.
- `rst_ctrl`, input, 1: synchronous, active-high reset.
- `target_in`, input, RESOLUTION_BITS: requested final duty.
- `step_in`, input, RESOLUTION_BITS: increment per update. Sampled with the target.
- `periods_in`, input, PERIOD_CNT_BITS: PWM periods between updates. Sampled with the target.
- `target_valid`, input, 1: request valid.
- `target_ready`, output, 1: controller can accept a request.
- `period_tick`, input, 1: one-cycle pulse at each PWM period start.
- `abort`, input, 1: stop the ramp and hold the current duty.
- `referencia_out`, output, RESOLUTION_BITS: duty reference to the generator.
- `busy`, output, 1: ramp in progress.
- `done`, output, 1: one-cycle pulse when `referencia_out` reaches the target.

## Operation

- States: IDLE, RAMP. All outputs are registered.
- Reset values: state IDLE, `referencia_out`=0, `target_ready`=1, `busy`=0, `done`=0, period counter 0.
- Handshake: a transfer occurs when `target_valid` & `target_ready` are both high in the same cycle. `target_ready`=1 exactly in IDLE. Inputs are sampled on the transfer cycle only.
- Sampling normalisation:
  - `step_in`=0 is latched as 1.
  - `periods_in`=0 is latched as 1.
- IDLE, on transfer:
  - If `target_in` == `referencia_out`: stay in IDLE and pulse `done` the next cycle.
  - Otherwise: go to RAMP, with `busy`=1 and `target_ready`=0 the next cycle, and the period counter cleared.
- RAMP, on `period_tick`:
  - If counter == latched periods − 1: clear the counter and update the reference. Otherwise increment the counter.
- Reference update arithmetic: computed in RESOLUTION_BITS+1 bits, with no wrap.
  - Up: new = (target − ref ≤ step) ? target : ref + step.
  - Down: new = (ref − target ≤ step) ? target : ref − step.
- Completion: if the updated value equals the target, then in the same cycle as that update:
  - `done` pulses;
  - the state returns to IDLE, with `busy`=0 and `target_ready`=1.
- `abort` in RAMP:
  - The next cycle is IDLE. `referencia_out` holds its value, the counter clears, and `done` is not asserted.
  - `abort` has priority over a simultaneous `period_tick`; no update occurs.
- `abort` in IDLE is ignored. A transfer in the same cycle is still accepted.
- Reset mid-ramp: all state returns to reset values. `referencia_out` drops to 0 on the next edge.

## Timing

- Latency from a `period_tick` sample edge to the new `referencia_out`: 1 cycle (registered).
- First update happens on the Nth `period_tick` after acceptance, where N = latched periods. A tick in the acceptance cycle itself is not counted.
- Full ramp length: ceil(|target − start| / step) × N ticks.
- `done` is high exactly one cycle. In the equal-target case, it comes 1 cycle after the transfer.
- New requests are not accepted during RAMP. A requester holds `target_valid` until `target_ready` is high.
- `period_tick` in IDLE has no effect.

## Test plan

- Reset, then idle 10 cycles → `referencia_out`=0, `target_ready`=1, `busy`=0, `done`=0.
- Target 200, step 50, periods 1, from 0 → `referencia_out` goes 50/100/150/200 on ticks 1–4. `done` pulses with 200, then `target_ready`=1.
- From 200: target 100, step 30, periods 2 → 170/140/110/100 on ticks 2/4/6/8. The final step is clamped, with no undershoot.
- From 250: target 255, step 10 → 255 after 1 tick, with no overflow. Repeat with step 0 and periods 0 → values treated as step 1, one update per tick.
- Target equal to current (100) → `done` 1 cycle after the handshake, `busy` never high.
- Target 200 from 0, step 10; `abort` asserted together with the 3rd tick → `referencia_out` holds 20, no `done`, IDLE. A reset asserted during a second ramp → `referencia_out`=0 the next cycle.
